// File: rtl/genius_sequencia_param.sv
`default_nettype none
// ============================================================================
// Module   : genius_sequencia_param
// Brief    : Parametrised "Genius" memory-game engine. The player builds the
//            sequence: each round, repeat every stored play, then add one new
//            play. Optional LED replay of the stored sequence: GENIUS_REPLAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module genius_sequencia_param #(
    parameter int N_BOTOES       = 4,
    parameter int ADDR_W         = 4,
    parameter int N_RODADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int REPLAY_CICLOS  = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [ADDR_W:0]     db_rodada,
    output logic [ADDR_W-1:0]   db_endereco,
    output logic [N_BOTOES-1:0] db_jogada,
    output logic [3:0]          db_estado
);

    localparam int                 c_TMO_W      = $clog2(TIMEOUT_CICLOS) + 1;
    localparam logic [c_TMO_W-1:0] c_TMO_ULTIMO = c_TMO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_UM     = c_TMO_W'(1);
    localparam logic [ADDR_W:0]    c_ROD_FINAL  = (ADDR_W + 1)'(N_RODADAS);
    localparam logic [ADDR_W:0]    c_ROD_UM     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  c_END_UM     = ADDR_W'(1);

    generate
        if (N_RODADAS < 1 || N_RODADAS > (1 << ADDR_W) ||
            TIMEOUT_CICLOS < 1 || REPLAY_CICLOS < 1) begin : g_param_invalido
            $error("genius_sequencia_param: parameter out of range");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_INICIAL     = 4'h0,
        S_PREPARA     = 4'h1,
        S_ESPERA      = 4'h2,
        S_REGISTRA    = 4'h3,
        S_COMPARA     = 4'h4,
        S_PROX_END    = 4'h5,
        S_ESPERA_NOVA = 4'h6,
        S_ESCREVE     = 4'h7,
        S_PROX_RODADA = 4'h8,
        S_REPLAY      = 4'h9,
        S_FIM_GANHOU  = 4'hA,
        S_FIM_TIMEOUT = 4'hD,
        S_FIM_ERRO    = 4'hE
    } estado_t;

    estado_t               r_estado;
    estado_t               w_proximo;
    logic [N_BOTOES-1:0]   r_b_q;
    logic [N_BOTOES-1:0]   r_b_qq;
    logic [ADDR_W:0]       r_rodada;
    logic [ADDR_W-1:0]     r_endereco;
    logic [N_BOTOES-1:0]   r_jogada;
    logic [c_TMO_W-1:0]    r_tmo;
    logic [N_BOTOES-1:0]   r_ram [0:(1 << ADDR_W)-1];

    logic w_press;
    logic w_nova_ok;
    logic w_tmo_fim;
    logic w_match;
    logic w_ultimo;

    // A press is the first non-zero sample after an all-zero one.
    assign w_press   = (r_b_q != '0) && (r_b_qq == '0);
    assign w_nova_ok = w_press && $onehot(r_b_q);
    assign w_tmo_fim = (r_tmo == c_TMO_ULTIMO);
    assign w_match   = $onehot(r_jogada) && (r_jogada == r_ram[r_endereco]);
    assign w_ultimo  = ({1'b0, r_endereco} == (r_rodada - c_ROD_UM));

`ifdef GENIUS_REPLAY_EN
    localparam int                 c_REP_W      = $clog2(REPLAY_CICLOS) + 1;
    localparam logic [c_REP_W-1:0] c_REP_ULTIMO = c_REP_W'(REPLAY_CICLOS - 1);
    localparam logic [c_REP_W-1:0] c_REP_UM     = c_REP_W'(1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_aceso;
    logic               w_rep_passo;
    logic               w_rep_fim;

    assign w_rep_passo = (r_rep_cnt == c_REP_ULTIMO);
    assign w_rep_fim   = w_rep_passo && !r_rep_aceso && w_ultimo;
    assign leds = (r_estado == S_REPLAY) ? (r_rep_aceso ? r_ram[r_endereco] : '0) : r_b_q;
`else
    assign leds = r_b_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= S_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            S_INICIAL, S_FIM_GANHOU, S_FIM_ERRO, S_FIM_TIMEOUT: begin
                if (iniciar) w_proximo = S_PREPARA;
            end
            S_PREPARA: w_proximo = S_ESPERA_NOVA;
            S_ESPERA: begin
                // A press on the expiry cycle still counts.
                if (w_press)        w_proximo = S_REGISTRA;
                else if (w_tmo_fim) w_proximo = S_FIM_TIMEOUT;
            end
            S_REGISTRA: w_proximo = S_COMPARA;
            S_COMPARA: begin
                if (!w_match)      w_proximo = S_FIM_ERRO;
                else if (w_ultimo) w_proximo = (r_rodada == c_ROD_FINAL) ? S_FIM_GANHOU
                                                                         : S_ESPERA_NOVA;
                else               w_proximo = S_PROX_END;
            end
            S_PROX_END: w_proximo = S_ESPERA;
            S_ESPERA_NOVA: begin
                if (w_nova_ok)      w_proximo = S_ESCREVE;
                else if (w_tmo_fim) w_proximo = S_FIM_TIMEOUT;
            end
            S_ESCREVE: w_proximo = S_PROX_RODADA;
`ifdef GENIUS_REPLAY_EN
            S_PROX_RODADA: w_proximo = S_REPLAY;
            S_REPLAY: begin
                if (w_rep_fim) w_proximo = S_ESPERA;
            end
`else
            S_PROX_RODADA: w_proximo = S_ESPERA;
`endif
            default: w_proximo = S_INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_b_q      <= '0;
            r_b_qq     <= '0;
            r_rodada   <= '0;
            r_endereco <= '0;
            r_jogada   <= '0;
            r_tmo      <= '0;
`ifdef GENIUS_REPLAY_EN
            r_rep_cnt   <= '0;
            r_rep_aceso <= 1'b0;
`endif
        end else begin
            r_b_q  <= botoes;
            r_b_qq <= r_b_q;
            case (r_estado)
                // Cleared on entry so PREPARA already shows round 0.
                S_INICIAL, S_FIM_GANHOU, S_FIM_ERRO, S_FIM_TIMEOUT: begin
                    if (iniciar) begin
                        r_rodada   <= '0;
                        r_endereco <= '0;
                        r_tmo      <= '0;
                    end
                end
                S_ESPERA: begin
                    if (w_press) begin
                        r_jogada <= r_b_q;
                        r_tmo    <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_UM;
                    end
                end
                S_ESPERA_NOVA: begin
                    if (w_nova_ok) begin
                        r_jogada <= r_b_q;
                        r_tmo    <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_UM;
                    end
                end
                S_PROX_END: r_endereco <= r_endereco + c_END_UM;
                S_PROX_RODADA: begin
                    r_rodada   <= r_rodada + c_ROD_UM;
                    r_endereco <= '0;
                    r_tmo      <= '0;
`ifdef GENIUS_REPLAY_EN
                    r_rep_cnt   <= '0;
                    r_rep_aceso <= 1'b1;
`endif
                end
`ifdef GENIUS_REPLAY_EN
                S_REPLAY: begin
                    if (w_rep_passo) begin
                        r_rep_cnt   <= '0;
                        r_rep_aceso <= !r_rep_aceso;
                        if (!r_rep_aceso) r_endereco <= w_ultimo ? '0 : r_endereco + c_END_UM;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + c_REP_UM;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Sequence RAM has no reset; every address is written before it is read.
    always_ff @(posedge clock) begin
        if (!reset && r_estado == S_ESCREVE) begin
            r_ram[r_rodada[ADDR_W-1:0]] <= r_jogada;
        end
    end

    assign pronto      = (r_estado == S_FIM_GANHOU) || (r_estado == S_FIM_ERRO) ||
                         (r_estado == S_FIM_TIMEOUT);
    assign ganhou      = (r_estado == S_FIM_GANHOU);
    assign perdeu      = (r_estado == S_FIM_ERRO) || (r_estado == S_FIM_TIMEOUT);
    assign db_timeout  = (r_estado == S_FIM_TIMEOUT);
    assign db_rodada   = r_rodada;
    assign db_endereco = r_endereco;
    assign db_jogada   = r_jogada;
    assign db_estado   = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_genius_sequencia_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_genius_sequencia_param
// Brief    : Self-checking bench for genius_sequencia_param (default build):
//            directed game scenarios plus randomized play vs. a game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_genius_sequencia_param;

    localparam int NB  = 4;
    localparam int AW  = 4;
    localparam int NR  = 4;
    localparam int TMO = 50;
    localparam int REP = 3;

    localparam int C_INI  = 0;
    localparam int C_PREP = 1;
    localparam int C_ESP  = 2;
    localparam int C_REG  = 3;
    localparam int C_CMP  = 4;
    localparam int C_PEND = 5;
    localparam int C_NOVA = 6;
    localparam int C_ESC  = 7;
    localparam int C_PROD = 8;
    localparam int C_WIN  = 10;
    localparam int C_TMO  = 13;
    localparam int C_ERR  = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [NB-1:0] botoes;
    logic [NB-1:0] leds;
    logic          pronto, ganhou, perdeu, db_timeout;
    logic [AW:0]   db_rodada;
    logic [AW-1:0] db_endereco;
    logic [NB-1:0] db_jogada;
    logic [3:0]    db_estado;

    always #5 clk = ~clk;

    genius_sequencia_param #(
        .N_BOTOES(NB), .ADDR_W(AW), .N_RODADAS(NR),
        .TIMEOUT_CICLOS(TMO), .REPLAY_CICLOS(REP)
    ) dut (
        .clock(clk), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_timeout(db_timeout), .db_rodada(db_rodada), .db_endereco(db_endereco),
        .db_jogada(db_jogada), .db_estado(db_estado)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- game model: event level, outcome decided at the press
    typedef struct { int code; int r; int e; logic [3:0] j; } snap_t;
    snap_t      m_sched[$];
    logic [3:0] m_seq[$];
    int         m_code = 0, m_r = 0, m_e = 0, m_idle = 0;
    logic [3:0] m_j = '0, m_bq = '0, m_bqq = '0;

    function automatic void m_show(input int c, input int r, input int e, input logic [3:0] j);
        m_code = c; m_r = r; m_e = e; m_j = j;
    endfunction

    function automatic void m_later(input int c, input int r, input int e, input logic [3:0] j);
        snap_t s;
        s.code = c; s.r = r; s.e = e; s.j = j;
        m_sched.push_back(s);
    endfunction

    function automatic void m_idle_tick();
        if (m_idle == TMO - 1) m_show(C_TMO, m_r, m_e, m_j);
        else m_idle++;
    endfunction

    always @(posedge clk) begin
        logic       pressed;
        logic [3:0] pv;
        snap_t      s;
        pressed = (m_bq != 4'd0) && (m_bqq == 4'd0);
        pv      = m_bq;
        if (reset) begin
            m_sched.delete();
            m_show(C_INI, 0, 0, 4'd0);
            m_bq = 4'd0; m_bqq = 4'd0; m_idle = 0;
        end else begin
            m_bqq = m_bq;
            m_bq  = botoes;
            if (m_sched.size() > 0) begin
                s = m_sched.pop_front();
                m_show(s.code, s.r, s.e, s.j);
            end else if (m_code inside {C_INI, C_WIN, C_ERR, C_TMO}) begin
                if (iniciar) begin
                    m_seq.delete();
                    m_idle = 0;
                    m_show(C_PREP, 0, 0, m_j);
                    m_later(C_NOVA, 0, 0, m_j);
                end
            end else if (m_code == C_ESP) begin
                if (pressed) begin
                    m_idle = 0;
                    m_show(C_REG, m_r, m_e, pv);
                    m_later(C_CMP, m_r, m_e, pv);
                    if (pv != m_seq[m_e])     m_later(C_ERR, m_r, m_e, pv);
                    else if (m_e == m_r - 1)  m_later((m_r == NR) ? C_WIN : C_NOVA, m_r, m_e, pv);
                    else begin
                        m_later(C_PEND, m_r, m_e, pv);
                        m_later(C_ESP, m_r, m_e + 1, pv);
                    end
                end else m_idle_tick();
            end else if (m_code == C_NOVA) begin
                if (pressed && $countones(pv) == 1) begin
                    m_idle = 0;
                    m_seq.push_back(pv);
                    m_show(C_ESC, m_r, m_e, pv);
                    m_later(C_PROD, m_r, m_e, pv);
                    m_later(C_ESP, m_r + 1, 0, pv);
                end else m_idle_tick();
            end
        end
    end

    always @(negedge clk) begin
        chk("estado", 32'(db_estado), m_code);
        chk("rodada", 32'(db_rodada), m_r);
        chk("endereco", 32'(db_endereco), m_e);
        chk("jogada", 32'(db_jogada), 32'(m_j));
        chk("leds", 32'(leds), 32'(m_bq));
        chk("pronto", 32'(pronto), 32'(m_code inside {C_WIN, C_ERR, C_TMO}));
        chk("ganhou", 32'(ganhou), 32'(m_code == C_WIN));
        chk("perdeu", 32'(perdeu), 32'(m_code inside {C_ERR, C_TMO}));
        chk("db_timeout", 32'(db_timeout), 32'(m_code == C_TMO));
    end

    task automatic press(input logic [3:0] v, input int hold, input int gap);
        botoes = v;
        repeat (hold) @(negedge clk);
        botoes = 4'd0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; iniciar = 1'b0; botoes = '0;
        repeat (3) @(negedge clk);
        chk("rst_estado", 32'(db_estado), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_flags", {28'd0, pronto, ganhou, perdeu, db_timeout}, 0);
        chk("rst_rodada", 32'(db_rodada), 0);
        chk("rst_jogada", 32'(db_jogada), 0);

        // iniciar held for 10 clocks: 0 -> 1 -> 6, then ignored
        reset = 1'b0; iniciar = 1'b1;
        @(negedge clk);
        chk("start_prepara", 32'(db_estado), 1);
        chk("start_rodada", 32'(db_rodada), 0);
        @(negedge clk);
        chk("start_nova", 32'(db_estado), 6);
        repeat (8) @(negedge clk);
        chk("start_held", 32'(db_estado), 6);
        chk("start_flags", {28'd0, pronto, ganhou, perdeu, db_timeout}, 0);
        iniciar = 1'b0;

        // full win with one-hot walk 0001, 0010, 0100, 1000
        for (int k = 0; k <= NR; k++) begin
            for (int i = 0; i < k; i++) press(4'(1 << i), 2, 4);
            if (k < NR) press(4'(1 << k), 2, 4);
        end
        chk("win_estado", 32'(db_estado), 32'hA);
        chk("win_flags", {28'd0, pronto, ganhou, perdeu, db_timeout}, 32'b1100);
        chk("win_rodada", 32'(db_rodada), 4);

        // held button is one play; wrong play in round 2 -> error
        start_game();
        press(4'b0001, 30, 4);
        chk("hold_estado", 32'(db_estado), 2);
        chk("hold_rodada", 32'(db_rodada), 1);
        press(4'b0001, 2, 4);
        press(4'b0010, 2, 4);
        press(4'b0001, 2, 4);
        press(4'b0100, 2, 2);
        chk("err_estado", 32'(db_estado), 32'hE);
        chk("err_flags", {28'd0, pronto, ganhou, perdeu, db_timeout}, 32'b1010);

        // restart from FIM_ERRO, non-one-hot insert ignored, then timeout
        iniciar = 1'b1;
        @(negedge clk);
        chk("restart_estado", 32'(db_estado), 1);
        chk("restart_rodada", 32'(db_rodada), 0);
        chk("restart_flags", {30'd0, ganhou, perdeu}, 0);
        iniciar = 1'b0;
        @(negedge clk);
        press(4'b0011, 2, 4);
        chk("multi_ignored", 32'(db_estado), 6);
        press(4'b0100, 2, 4);
        press(4'b0100, 2, 4);
        press(4'b0001, 2, 4);
        repeat (47) @(negedge clk);
        chk("tmo_not_yet", 32'(db_estado), 2);
        @(negedge clk);
        chk("tmo_estado", 32'(db_estado), 32'hD);
        chk("tmo_flags", {28'd0, pronto, ganhou, perdeu, db_timeout}, 32'b1011);

        // reset in the middle of a registered press
        start_game();
        press(4'b0001, 2, 4);
        botoes = 4'b0001;
        repeat (2) @(negedge clk);
        chk("mid_registra", 32'(db_estado), 3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_estado", 32'(db_estado), 0);
        chk("midrst_outs", {leds, pronto, ganhou, perdeu, db_timeout, db_rodada,
                            db_endereco, db_jogada}, 0);
        reset = 1'b0; botoes = '0;
        @(negedge clk);

        // randomized play, mostly correct so games progress
        for (int it = 0; it < 300; it++) begin
            int         sel;
            logic [3:0] v;
            sel = $urandom_range(0, 99);
            if (m_code inside {C_INI, C_WIN, C_ERR, C_TMO}) begin
                if (sel < 30) repeat ($urandom_range(1, 3)) @(negedge clk);
                start_game();
            end else if (sel < 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else if (sel < 5) begin
                repeat ($urandom_range(45, 55)) @(negedge clk);
            end else begin
                if (sel < 88 && m_code == C_ESP) v = m_seq[m_e];
                else if (sel < 95)               v = 4'(1 << $urandom_range(0, 3));
                else                             v = 4'($urandom_range(0, 15));
                press(v, $urandom_range(1, 4), $urandom_range(0, 6));
            end
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
